btn_conditioner: RTL and testbench

Four-channel push-button conditioner placed directly upstream of the top-level control logic, between the raw board buttons and the logic's `BTN` input. Each channel synchronises its asynchronous button into the `clk` domain and filters contact bounce with a per-channel counter/FSM. It then presents a stable level plus single-cycle press, release and long-press pulses. Channels are fully independent.

---
 rtl/btn_conditioner.sv | 159 +++++++++++++++
 tb/tb_btn_conditioner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Four-channel push-button conditioner. Each raw button is synchronised into
// the clk domain, debounced by a per-channel FSM/counter, and presented as a
// stable level plus one-cycle press, release and long-press pulses.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   BTN_RAW      raw asynchronous buttons, 1 = pressed
//   BTN_LEVEL    debounced level
//   BTN_PRESS    one-cycle pulse on accepted 0->1
//   BTN_RELEASE  one-cycle pulse on accepted 1->0
//   BTN_HOLD     one-cycle pulse once per press after HOLD_CYCLES held
//   ANY_PRESS    OR of BTN_PRESS, aligned with it
//
// state | meaning
// LOW   | debounced level 0, idle
// RISE  | s seen high, counting toward acceptance of a press
// HIGH  | debounced level 1, counting toward long press (saturates at H)
// FALL  | s seen low, counting toward acceptance of a release
module btn_conditioner #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] BTN_RAW,
   output logic [WIDTH-1:0] BTN_LEVEL,
   output logic [WIDTH-1:0] BTN_PRESS,
   output logic [WIDTH-1:0] BTN_RELEASE,
   output logic [WIDTH-1:0] BTN_HOLD,
   output logic             ANY_PRESS
);

   localparam int unsigned MAXC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } state_t;

   logic [WIDTH-1:0] sync1_q, sync2_q;
   state_t           state_q [WIDTH];
   state_t           state_d [WIDTH];
   logic [CW-1:0]    cnt_q   [WIDTH];
   logic [CW-1:0]    cnt_d   [WIDTH];

   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] press_q, press_d;
   logic [WIDTH-1:0] release_q, release_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             any_q, any_d;

   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      hold_d    = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_LOW: begin
               cnt_d[i] = '0;
               if (sync2_q[i]) begin
                  state_d[i] = S_RISE;
                  cnt_d[i]   = CNT_ONE;
               end
            end
            S_RISE: begin
               if (!sync2_q[i]) begin
                  state_d[i] = S_LOW;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DEB_LAST) begin
                  state_d[i] = S_HIGH;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b1;
                  press_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!sync2_q[i]) begin
                  state_d[i] = S_FALL;
                  cnt_d[i]   = CNT_ONE;
               end else if (cnt_q[i] != HOLD_MAX) begin
                  // Saturation at H keeps an indefinitely held button to one hold pulse.
                  cnt_d[i]  = cnt_q[i] + CNT_ONE;
                  hold_d[i] = (cnt_q[i] == HOLD_LAST);
               end
            end
            S_FALL: begin
               if (sync2_q[i]) begin
                  // Back to HIGH already saturated: a bounce never re-arms the hold pulse.
                  state_d[i] = S_HIGH;
                  cnt_d[i]   = HOLD_MAX;
               end else if (cnt_q[i] == DEB_LAST) begin
                  state_d[i]   = S_LOW;
                  cnt_d[i]     = '0;
                  level_d[i]   = 1'b0;
                  release_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = S_LOW;
               cnt_d[i]   = '0;
            end
         endcase
      end
      any_d = |press_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         hold_q    <= '0;
         any_q     <= 1'b0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            state_q[i] <= S_LOW;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q   <= BTN_RAW;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         hold_q    <= hold_d;
         any_q     <= any_d;
         for (int i = 0; i < int'(WIDTH); i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign BTN_LEVEL   = level_q;
   assign BTN_PRESS   = press_q;
   assign BTN_RELEASE = release_q;
   assign BTN_HOLD    = hold_q;
   assign ANY_PRESS   = any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

   logic       clk;
   logic       reset;
   logic [3:0] BTN_RAW;
   logic [3:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_HOLD;
   logic       ANY_PRESS;

   int total = 0;
   int bad   = 0;

   int press_n [4];
   int rel_n   [4];
   int hold_n  [4];
   int bp, br, bh;

   btn_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .BTN_RAW     (BTN_RAW),
      .BTN_LEVEL   (BTN_LEVEL),
      .BTN_PRESS   (BTN_PRESS),
      .BTN_RELEASE (BTN_RELEASE),
      .BTN_HOLD    (BTN_HOLD),
      .ANY_PRESS   (ANY_PRESS)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 4; i++) begin
         press_n[i] = 0;
         rel_n[i]   = 0;
         hold_n[i]  = 0;
      end
   end

   // Pulse tallies sampled mid-cycle so each one-cycle pulse counts once.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (BTN_PRESS[i])   press_n[i] = press_n[i] + 1;
         if (BTN_RELEASE[i]) rel_n[i]   = rel_n[i] + 1;
         if (BTN_HOLD[i])    hold_n[i]  = hold_n[i] + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] outs();
      return {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_HOLD, ANY_PRESS};
   endfunction

   initial begin
      reset   = 1'b0;
      BTN_RAW = 4'b1111;
      #2;
      chk("reset_t0_outs", 32'(outs()), 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick(1);
         chk("reset_hold_outs", 32'(outs()), 32'h0);
      end
      reset = 1'b1;

      // Buttons held through reset: press 5 edges after first sampling edge
      tick(5);
      chk("rst_press_early", 32'(BTN_PRESS), 32'h0);
      chk("rst_level_early", 32'(BTN_LEVEL), 32'h0);
      tick(1);
      chk("rst_press", 32'(BTN_PRESS), 32'hF);
      chk("rst_any", 32'(ANY_PRESS), 32'h1);
      chk("rst_level", 32'(BTN_LEVEL), 32'hF);
      tick(1);
      chk("rst_press_end", 32'(BTN_PRESS), 32'h0);
      chk("rst_any_end", 32'(ANY_PRESS), 32'h0);
      chk("rst_level_hold", 32'(BTN_LEVEL), 32'hF);

      BTN_RAW = 4'b0000;
      tick(5);
      chk("all_rel_early", 32'(BTN_RELEASE), 32'h0);
      tick(1);
      chk("all_rel", 32'(BTN_RELEASE), 32'hF);
      chk("all_rel_level", 32'(BTN_LEVEL), 32'h0);
      chk("all_rel_nopress", 32'(BTN_PRESS), 32'h0);
      tick(1);
      chk("all_rel_end", 32'(BTN_RELEASE), 32'h0);

      // Clean press/release on ch0
      bp = press_n[0]; br = rel_n[0]; bh = hold_n[0];
      BTN_RAW = 4'b0001;
      tick(5);
      chk("c0_level_early", 32'(BTN_LEVEL), 32'h0);
      tick(1);
      chk("c0_level", 32'(BTN_LEVEL), 32'h1);
      chk("c0_press", 32'(BTN_PRESS), 32'h1);
      tick(1);
      chk("c0_press_end", 32'(BTN_PRESS), 32'h0);
      tick(3);
      BTN_RAW = 4'b0000;
      tick(5);
      chk("c0_fall_early", 32'(BTN_LEVEL), 32'h1);
      chk("c0_rel_early", 32'(BTN_RELEASE), 32'h0);
      tick(1);
      chk("c0_fall", 32'(BTN_LEVEL), 32'h0);
      chk("c0_rel", 32'(BTN_RELEASE), 32'h1);
      tick(1);
      chk("c0_rel_end", 32'(BTN_RELEASE), 32'h0);
      chk("c0_press_cnt", 32'(press_n[0] - bp), 32'd1);
      chk("c0_rel_cnt", 32'(rel_n[0] - br), 32'd1);
      chk("c0_hold_cnt", 32'(hold_n[0] - bh), 32'd0);

      // Bounce on ch1: 1,0,1,1,0 then stable 1
      bp = press_n[1];
      BTN_RAW = 4'b0010; tick(1);
      BTN_RAW = 4'b0000; tick(1);
      BTN_RAW = 4'b0010; tick(1);
      BTN_RAW = 4'b0010; tick(1);
      BTN_RAW = 4'b0000; tick(1);
      BTN_RAW = 4'b0010;
      tick(5);
      chk("c1_bounce_nopress", 32'(press_n[1] - bp), 32'd0);
      chk("c1_bounce_level0", 32'(BTN_LEVEL), 32'h0);
      tick(1);
      chk("c1_press", 32'(BTN_PRESS), 32'h2);
      chk("c1_level", 32'(BTN_LEVEL), 32'h2);
      tick(1);
      chk("c1_press_end", 32'(BTN_PRESS), 32'h0);
      BTN_RAW = 4'b0000;
      tick(7);
      chk("c1_press_cnt", 32'(press_n[1] - bp), 32'd1);
      chk("c1_level_off", 32'(BTN_LEVEL), 32'h0);

      // Glitch of D-1 cycles on ch2
      bp = press_n[2]; br = rel_n[2]; bh = hold_n[2];
      BTN_RAW = 4'b0100;
      tick(3);
      BTN_RAW = 4'b0000;
      tick(10);
      chk("c2_glitch_level", 32'(BTN_LEVEL), 32'h0);
      chk("c2_glitch_pulses", 32'((press_n[2] - bp) + (rel_n[2] - br) + (hold_n[2] - bh)), 32'd0);

      // Long press on ch3 with a 2-cycle low glitch after the hold pulse
      bp = press_n[3]; br = rel_n[3]; bh = hold_n[3];
      BTN_RAW = 4'b1000;
      tick(6);
      chk("c3_press", 32'(BTN_PRESS), 32'h8);
      tick(15);
      chk("c3_hold_early", 32'(BTN_HOLD), 32'h0);
      tick(1);
      chk("c3_hold", 32'(BTN_HOLD), 32'h8);
      tick(1);
      chk("c3_hold_end", 32'(BTN_HOLD), 32'h0);
      BTN_RAW = 4'b0000;
      tick(2);
      BTN_RAW = 4'b1000;
      tick(3);
      chk("c3_glitch_level", 32'(BTN_LEVEL), 32'h8);
      chk("c3_glitch_norel", 32'(rel_n[3] - br), 32'd0);
      tick(12);
      chk("c3_hold_cnt", 32'(hold_n[3] - bh), 32'd1);
      chk("c3_press_cnt", 32'(press_n[3] - bp), 32'd1);
      BTN_RAW = 4'b0000;
      tick(7);
      chk("c3_rel_cnt", 32'(rel_n[3] - br), 32'd1);
      chk("c3_hold_cnt_final", 32'(hold_n[3] - bh), 32'd1);
      chk("c3_level_off", 32'(BTN_LEVEL), 32'h0);

      // Simultaneous ch0 + ch2
      BTN_RAW = 4'b0101;
      tick(5);
      chk("sim_press_early", 32'(BTN_PRESS), 32'h0);
      tick(1);
      chk("sim_press", 32'(BTN_PRESS), 32'h5);
      chk("sim_any", 32'(ANY_PRESS), 32'h1);
      BTN_RAW = 4'b0000;
      tick(7);
      chk("sim_level_off", 32'(BTN_LEVEL), 32'h0);

      // Reset while ch1 in RISE (ch3 debounced high), button released during reset
      BTN_RAW = 4'b1000;
      tick(7);
      chk("pre_rst_level", 32'(BTN_LEVEL), 32'h8);
      BTN_RAW = 4'b1010;
      tick(3);
      reset = 1'b0;
      #2;
      chk("async_rst_outs_a", 32'(outs()), 32'h0);
      BTN_RAW = 4'b0000;
      tick(2);
      reset = 1'b1;
      bp = press_n[0] + press_n[1] + press_n[2] + press_n[3];
      tick(10);
      chk("rst_a_nopress", 32'(press_n[0] + press_n[1] + press_n[2] + press_n[3] - bp), 32'd0);
      chk("rst_a_level", 32'(BTN_LEVEL), 32'h0);

      // Reset while ch1 in RISE, ch1 still pressed at release
      BTN_RAW = 4'b0010;
      tick(3);
      reset = 1'b0;
      #2;
      chk("async_rst_outs_b", 32'(outs()), 32'h0);
      tick(2);
      reset = 1'b1;
      tick(5);
      chk("rst_b_press_early", 32'(BTN_PRESS), 32'h0);
      tick(1);
      chk("rst_b_press", 32'(BTN_PRESS), 32'h2);
      chk("rst_b_level", 32'(BTN_LEVEL), 32'h2);
      BTN_RAW = 4'b0000;
      tick(7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
